// File: rtl/ibex_wb_buffer.sv
// ibex_wb_buffer: in-order writeback buffer between execute/LSU and the
// register file write port. Results are queued in a circular FIFO. Loads wait
// in their entry until the LSU response fills them. Entries retire one per
// cycle, in order. The buffer also supplies forwarded operands and a stall
// hazard to the ID read path.
// Optional feature macro: IBEX_WB_FWD_EN. When it is defined, operands are
// forwarded from the youngest matching entry. When it is undefined, there is
// no forwarding, and any in-flight match raises the hazard.
module ibex_wb_buffer #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_wb_i,
  input  logic                 instr_is_load_i,
  input  logic [4:0]           rf_waddr_id_i,
  input  logic [DataWidth-1:0] rf_wdata_id_i,
  input  logic                 rf_we_id_i,
  output logic                 wb_ready_o,
  input  logic                 lsu_resp_valid_i,
  input  logic [DataWidth-1:0] lsu_resp_data_i,
  input  logic                 lsu_resp_err_i,
  output logic [4:0]           rf_waddr_wb_o,
  output logic [DataWidth-1:0] rf_wdata_wb_o,
  output logic                 rf_we_wb_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 fwd_a_valid_o,
  output logic                 fwd_b_valid_o,
  output logic [DataWidth-1:0] fwd_a_data_o,
  output logic [DataWidth-1:0] fwd_b_data_o,
  output logic                 hazard_o,
  output logic [2:0]           count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  typedef logic [PtrW-1:0] ptr_t;

  logic [Depth-1:0]     r_valid;
  logic [Depth-1:0]     r_we;
  logic [Depth-1:0]     r_load;
  logic [Depth-1:0]     r_filled;
  logic [4:0]           r_addr [Depth];
  logic [DataWidth-1:0] r_data [Depth];
  ptr_t                 r_head;
  ptr_t                 r_tail;
  logic [2:0]           r_count;

  logic w_head_valid;
  logic w_retire;
  logic w_ready;
  logic w_push;
  logic w_fill_hit;
  ptr_t w_fill_idx;
  logic w_fill_existing;
  logic w_fill_push;

  // Head status, retire and push acceptance. All outputs are forced low while in reset.
  always_comb begin
    w_head_valid = r_valid[r_head];
    w_retire     = rst_ni && w_head_valid && r_filled[r_head];
    w_ready      = rst_ni && ((r_count < 3'(Depth)) || w_retire);
    w_push       = en_wb_i && w_ready;
  end

  // Find the oldest valid unfilled load. Scanning starts at the head.
  always_comb begin
    ptr_t v_idx;
    v_idx      = '0;
    w_fill_hit = 1'b0;
    w_fill_idx = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      v_idx = r_head + ptr_t'(i);
      if (!w_fill_hit && r_valid[v_idx] && r_load[v_idx] && !r_filled[v_idx]) begin
        w_fill_hit = 1'b1;
        w_fill_idx = v_idx;
      end
    end
    w_fill_existing = lsu_resp_valid_i && w_fill_hit;
    w_fill_push     = lsu_resp_valid_i && !w_fill_hit && w_push && instr_is_load_i;
  end

  // Drive the register file write port from the head entry.
  always_comb begin
    rf_waddr_wb_o = (rst_ni && w_head_valid) ? r_addr[r_head] : '0;
    rf_wdata_wb_o = (rst_ni && w_head_valid) ? r_data[r_head] : '0;
    rf_we_wb_o    = w_retire && r_we[r_head] && (r_addr[r_head] != '0);
    wb_ready_o    = w_ready;
    count_o       = rst_ni ? r_count : '0;
  end

`ifdef IBEX_WB_FWD_EN
  // Forward from the youngest matching entry. Later matches in the scan override earlier ones.
  always_comb begin
    ptr_t v_idx;
    logic v_a_match, v_a_filled, v_b_match, v_b_filled;
    logic [DataWidth-1:0] v_a_data, v_b_data;
    v_idx      = '0;
    v_a_match  = 1'b0;
    v_a_filled = 1'b0;
    v_a_data   = '0;
    v_b_match  = 1'b0;
    v_b_filled = 1'b0;
    v_b_data   = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      v_idx = r_head + ptr_t'(i);
      if (r_valid[v_idx] && r_we[v_idx] && (r_addr[v_idx] != '0)) begin
        if (r_addr[v_idx] == raddr_a_i) begin
          v_a_match  = 1'b1;
          v_a_filled = r_filled[v_idx];
          v_a_data   = r_data[v_idx];
        end
        if (r_addr[v_idx] == raddr_b_i) begin
          v_b_match  = 1'b1;
          v_b_filled = r_filled[v_idx];
          v_b_data   = r_data[v_idx];
        end
      end
    end
    fwd_a_valid_o = rst_ni && v_a_match && v_a_filled;
    fwd_b_valid_o = rst_ni && v_b_match && v_b_filled;
    fwd_a_data_o  = fwd_a_valid_o ? v_a_data : '0;
    fwd_b_data_o  = fwd_b_valid_o ? v_b_data : '0;
    hazard_o      = rst_ni && ((v_a_match && !v_a_filled) || (v_b_match && !v_b_filled));
  end
`else
  // No forwarding: any in-flight writer of a read register stalls ID.
  always_comb begin
    logic v_any;
    v_any = 1'b0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (r_valid[i] && r_we[i] && (r_addr[i] != '0) &&
          ((r_addr[i] == raddr_a_i) || (r_addr[i] == raddr_b_i))) begin
        v_any = 1'b1;
      end
    end
    fwd_a_valid_o = 1'b0;
    fwd_b_valid_o = 1'b0;
    fwd_a_data_o  = '0;
    fwd_b_data_o  = '0;
    hazard_o      = rst_ni && v_any;
  end
`endif

  // FIFO state update. When the buffer is full, a pop and a push in the same
  // cycle share the head slot. The push is written last so that it takes precedence.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_valid  <= '0;
      r_we     <= '0;
      r_load   <= '0;
      r_filled <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_retire) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + ptr_t'(1);
      end
      if (w_fill_existing) begin
        r_filled[w_fill_idx] <= 1'b1;
        r_data[w_fill_idx]   <= lsu_resp_data_i;
        if (lsu_resp_err_i) begin
          r_we[w_fill_idx] <= 1'b0;
        end
      end
      if (w_push) begin
        r_valid[r_tail]  <= 1'b1;
        r_addr[r_tail]   <= rf_waddr_id_i;
        r_data[r_tail]   <= instr_is_load_i ? (w_fill_push ? lsu_resp_data_i : '0)
                                            : rf_wdata_id_i;
        r_we[r_tail]     <= rf_we_id_i && !(w_fill_push && lsu_resp_err_i);
        r_load[r_tail]   <= instr_is_load_i;
        r_filled[r_tail] <= !instr_is_load_i || w_fill_push;
        r_tail           <= r_tail + ptr_t'(1);
      end
      r_count <= r_count + 3'(w_push) - 3'(w_retire);
    end
  end

endmodule

// File: tb/tb_ibex_wb_buffer.sv
// Directed testbench for ibex_wb_buffer with Depth=2. The forwarding
// expectations follow IBEX_WB_FWD_EN.
module tb_ibex_wb_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        en_wb_i;
  logic        instr_is_load_i;
  logic [4:0]  rf_waddr_id_i;
  logic [31:0] rf_wdata_id_i;
  logic        rf_we_id_i;
  logic        wb_ready_o;
  logic        lsu_resp_valid_i;
  logic [31:0] lsu_resp_data_i;
  logic        lsu_resp_err_i;
  logic [4:0]  rf_waddr_wb_o;
  logic [31:0] rf_wdata_wb_o;
  logic        rf_we_wb_o;
  logic [4:0]  raddr_a_i;
  logic [4:0]  raddr_b_i;
  logic        fwd_a_valid_o;
  logic        fwd_b_valid_o;
  logic [31:0] fwd_a_data_o;
  logic [31:0] fwd_b_data_o;
  logic        hazard_o;
  logic [2:0]  count_o;

  int n_checks = 0;
  int n_errors = 0;

  ibex_wb_buffer #(.DataWidth(32), .Depth(2)) u_dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .en_wb_i         (en_wb_i),
    .instr_is_load_i (instr_is_load_i),
    .rf_waddr_id_i   (rf_waddr_id_i),
    .rf_wdata_id_i   (rf_wdata_id_i),
    .rf_we_id_i      (rf_we_id_i),
    .wb_ready_o      (wb_ready_o),
    .lsu_resp_valid_i(lsu_resp_valid_i),
    .lsu_resp_data_i (lsu_resp_data_i),
    .lsu_resp_err_i  (lsu_resp_err_i),
    .rf_waddr_wb_o   (rf_waddr_wb_o),
    .rf_wdata_wb_o   (rf_wdata_wb_o),
    .rf_we_wb_o      (rf_we_wb_o),
    .raddr_a_i       (raddr_a_i),
    .raddr_b_i       (raddr_b_i),
    .fwd_a_valid_o   (fwd_a_valid_o),
    .fwd_b_valid_o   (fwd_b_valid_o),
    .fwd_a_data_o    (fwd_a_data_o),
    .fwd_b_data_o    (fwd_b_data_o),
    .hazard_o        (hazard_o),
    .count_o         (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    en_wb_i          = 1'b0;
    instr_is_load_i  = 1'b0;
    rf_waddr_id_i    = '0;
    rf_wdata_id_i    = '0;
    rf_we_id_i       = 1'b0;
    lsu_resp_valid_i = 1'b0;
    lsu_resp_data_i  = '0;
    lsu_resp_err_i   = 1'b0;
    raddr_a_i        = '0;
    raddr_b_i        = '0;
  endtask

  task automatic push(input logic [4:0] addr, input logic [31:0] data, input logic is_load);
    en_wb_i         = 1'b1;
    instr_is_load_i = is_load;
    rf_waddr_id_i   = addr;
    rf_wdata_id_i   = data;
    rf_we_id_i      = 1'b1;
  endtask

  task automatic resp(input logic [31:0] data, input logic err);
    lsu_resp_valid_i = 1'b1;
    lsu_resp_data_i  = data;
    lsu_resp_err_i   = err;
  endtask

  task automatic chk_wb(input string tag, input logic we, input logic [4:0] addr,
                        input logic [31:0] data, input logic [2:0] cnt);
    check_eq({tag, "_we"},    32'(rf_we_wb_o),    32'(we));
    check_eq({tag, "_waddr"}, 32'(rf_waddr_wb_o), 32'(addr));
    check_eq({tag, "_wdata"}, rf_wdata_wb_o,      data);
    check_eq({tag, "_count"}, 32'(count_o),       32'(cnt));
  endtask

  initial begin
    idle();
    rst_ni = 1'b0;
    tick();
    tick();
    #1;
    check_eq("rst_count", 32'(count_o), 0);
    check_eq("rst_ready", 32'(wb_ready_o), 0);
    check_eq("rst_we", 32'(rf_we_wb_o), 0);
    check_eq("rst_hazard", 32'(hazard_o), 0);
    rst_ni = 1'b1;
    tick();

    // A single non-load retires in the cycle after it is pushed.
    push(5'd5, 32'hDEADBEEF, 1'b0);
    #1 check_eq("t1_ready", 32'(wb_ready_o), 1);
    tick();
    idle();
    raddr_a_i = 5'd5;
    #1 chk_wb("t1_ret", 1'b1, 5'd5, 32'hDEADBEEF, 3'd1);
`ifdef IBEX_WB_FWD_EN
    check_eq("t1_fwd_a_v", 32'(fwd_a_valid_o), 1);
    check_eq("t1_fwd_a_d", fwd_a_data_o, 32'hDEADBEEF);
`else
    check_eq("t1_hazard", 32'(hazard_o), 1);
`endif
    tick();
    raddr_a_i = '0;
    #1 chk_wb("t1_empty", 1'b0, 5'd0, 32'h0, 3'd0);

    // A load followed by a non-load. The non-load waits behind the load until the response arrives.
    push(5'd3, 32'h0, 1'b1);
    tick();
    push(5'd4, 32'h11, 1'b0);
    #1 check_eq("t2_wait0_we", 32'(rf_we_wb_o), 0);
    check_eq("t2_wait0_waddr", 32'(rf_waddr_wb_o), 3);
    tick();
    idle();
    raddr_a_i = 5'd3;
    raddr_b_i = 5'd4;
    #1 check_eq("t2_count", 32'(count_o), 2);
    check_eq("t2_we1", 32'(rf_we_wb_o), 0);
    check_eq("t2_hazard", 32'(hazard_o), 1);
    check_eq("t2_fwd_a_v", 32'(fwd_a_valid_o), 0);
`ifdef IBEX_WB_FWD_EN
    check_eq("t2_fwd_b_v", 32'(fwd_b_valid_o), 1);
    check_eq("t2_fwd_b_d", fwd_b_data_o, 32'h11);
`else
    check_eq("t2_fwd_b_v", 32'(fwd_b_valid_o), 0);
`endif
    tick();
    #1 check_eq("t2_we2", 32'(rf_we_wb_o), 0);
    tick();
    #1 check_eq("t2_we3", 32'(rf_we_wb_o), 0);
    resp(32'h22, 1'b0);
    #1 check_eq("t2_we_resp", 32'(rf_we_wb_o), 0);
    tick();
    idle();
    #1 chk_wb("t2_x3", 1'b1, 5'd3, 32'h22, 3'd2);
    tick();
    #1 chk_wb("t2_x4", 1'b1, 5'd4, 32'h11, 3'd1);
    tick();
    #1 check_eq("t2_empty", 32'(count_o), 0);

    // Two unfilled loads fill the buffer. A response frees the head, and a pop and a push then happen in the same cycle.
    push(5'd1, 32'h0, 1'b1);
    tick();
    push(5'd2, 32'h0, 1'b1);
    tick();
    push(5'd6, 32'h66, 1'b0);
    #1 check_eq("t3_full_count", 32'(count_o), 2);
    check_eq("t3_full_ready", 32'(wb_ready_o), 0);
    tick();
    #1 check_eq("t3_held_count", 32'(count_o), 2);
    check_eq("t3_held_ready", 32'(wb_ready_o), 0);
    resp(32'hAA, 1'b0);
    tick();
    lsu_resp_valid_i = 1'b0;
    #1 check_eq("t3_pp_ready", 32'(wb_ready_o), 1);
    chk_wb("t3_x1", 1'b1, 5'd1, 32'hAA, 3'd2);
    tick();
    idle();
    #1 chk_wb("t3_after", 1'b0, 5'd2, 32'h0, 3'd2);
    resp(32'hBB, 1'b0);
    tick();
    idle();
    #1 chk_wb("t3_x2", 1'b1, 5'd2, 32'hBB, 3'd2);
    tick();
    #1 chk_wb("t3_x6", 1'b1, 5'd6, 32'h66, 3'd1);
    tick();
    #1 check_eq("t3_empty", 32'(count_o), 0);

    // Two filled entries write x7. Forwarding must return the younger value.
    push(5'd8, 32'h0, 1'b1);
    tick();
    push(5'd7, 32'hA, 1'b0);
    tick();
    idle();
    resp(32'h88, 1'b0);
    #1 check_eq("t4_ready0", 32'(wb_ready_o), 0);
    tick();
    idle();
    push(5'd7, 32'hB, 1'b0);
    #1 check_eq("t4_x8_we", 32'(rf_we_wb_o), 1);
    check_eq("t4_x8_waddr", 32'(rf_waddr_wb_o), 8);
    tick();
    idle();
    raddr_b_i = 5'd7;
    raddr_a_i = 5'd0;
    #1 chk_wb("t4_xA", 1'b1, 5'd7, 32'hA, 3'd2);
    check_eq("t4_fwd_a_v", 32'(fwd_a_valid_o), 0);
`ifdef IBEX_WB_FWD_EN
    check_eq("t4_fwd_b_v", 32'(fwd_b_valid_o), 1);
    check_eq("t4_fwd_b_d", fwd_b_data_o, 32'hB);
    check_eq("t4_hazard", 32'(hazard_o), 0);
`else
    check_eq("t4_fwd_b_v", 32'(fwd_b_valid_o), 0);
    check_eq("t4_hazard", 32'(hazard_o), 1);
`endif
    tick();
    raddr_b_i = '0;
    #1 chk_wb("t4_xB", 1'b1, 5'd7, 32'hB, 3'd1);
    tick();
    #1 check_eq("t4_empty", 32'(count_o), 0);

    // A faulting load and an x0 destination both retire without writing.
    push(5'd9, 32'h0, 1'b1);
    tick();
    push(5'd0, 32'h55, 1'b0);
    resp(32'h99, 1'b1);
    tick();
    idle();
    #1 chk_wb("t5_x9", 1'b0, 5'd9, 32'h99, 3'd2);
    tick();
    #1 chk_wb("t5_x0", 1'b0, 5'd0, 32'h55, 3'd1);
    tick();
    #1 check_eq("t5_empty", 32'(count_o), 0);
    resp(32'h123, 1'b0);
    tick();
    idle();
    #1 chk_wb("t5_spur", 1'b0, 5'd0, 32'h0, 3'd0);

    // A response in the same cycle fills a load that is being pushed into an empty buffer.
    push(5'd13, 32'h0, 1'b1);
    resp(32'h1313, 1'b0);
    tick();
    idle();
    #1 chk_wb("t5b_x13", 1'b1, 5'd13, 32'h1313, 3'd1);
    tick();
    #1 check_eq("t5b_empty", 32'(count_o), 0);

    // Reset while two loads are pending. A late response after the reset is dropped.
    push(5'd10, 32'h0, 1'b1);
    tick();
    push(5'd11, 32'h0, 1'b1);
    raddr_a_i = 5'd10;
    #1 check_eq("t6_hazard", 32'(hazard_o), 1);
    tick();
    idle();
    #1 check_eq("t6_pend", 32'(count_o), 2);
    rst_ni = 1'b0;
    tick();
    #1 chk_wb("t6_rst", 1'b0, 5'd0, 32'h0, 3'd0);
    check_eq("t6_rst_ready", 32'(wb_ready_o), 0);
    rst_ni = 1'b1;
    resp(32'h77, 1'b0);
    tick();
    idle();
    #1 chk_wb("t6_late", 1'b0, 5'd0, 32'h0, 3'd0);
    push(5'd12, 32'h12, 1'b0);
    tick();
    idle();
    #1 chk_wb("t6_post", 1'b1, 5'd12, 32'h12, 3'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ibex_wb_buffer.md
# ibex_wb_buffer

In-order writeback buffer between the execute/LSU side and the register file write port. It queues completed and pending-load results and retires them one per cycle onto the register file write port. It also supplies forwarded operands and a hazard flag to the ID stage read path. Loads occupy an entry until their LSU response arrives; entries retire strictly in order.

## Interface
Parameters:
- DataWidth, 32, width of result data
- Depth, 2, number of buffer entries; legal values 2 or 4

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low; sampled on the rising edge of clk_i
- en_wb_i  in  1  ID/EX presents a result to push
- instr_is_load_i  in  1  pushed entry is a load; its data comes later from the LSU
- rf_waddr_id_i  in  5  destination register of the pushed entry
- rf_wdata_id_i  in  DataWidth  result data; ignored for loads
- rf_we_id_i  in  1  pushed entry writes the register file
- wb_ready_o  out  1  push accepted this cycle
- lsu_resp_valid_i  in  1  load data valid
- lsu_resp_data_i  in  DataWidth  load data
- lsu_resp_err_i  in  1  load faulted
- rf_waddr_wb_o  out  5  register file write address
- rf_wdata_wb_o  out  DataWidth  register file write data
- rf_we_wb_o  out  1  register file write enable
- raddr_a_i, raddr_b_i  in  5 each  ID read addresses
- fwd_a_valid_o, fwd_b_valid_o  out  1 each  forwarded data overrides the register file read
- fwd_a_data_o, fwd_b_data_o  out  DataWidth each  forwarded data
- hazard_o  out  1  a read address depends on an unfilled load; ID must stall
- count_o  out  3  occupied entries

## Operation
- Each entry holds {valid, addr, data, we, is_load, filled}. Entries are organised as a circular FIFO with head and tail pointers that wrap modulo Depth.
- Push: occurs when en_wb_i && wb_ready_o. A non-load entry is pushed with filled=1. A load entry is pushed with filled=0.
- wb_ready_o = (count < Depth) || retire. Push and pop may happen in the same cycle when the buffer is full.
- Fill: lsu_resp_valid_i fills the oldest valid unfilled load present at the start of the cycle.
  - If no such load exists, the response fills a load being pushed in the same cycle.
  - Otherwise the response is dropped.
  - When the response fills an entry, that entry's data is set to lsu_resp_data_i, and its we is cleared if lsu_resp_err_i is set.
- Retire: retire = head.valid && head.filled. On retire the head is popped and rf_we_wb_o = head.we && (head.addr != 0); addr and data are driven from the head entry.
  - An x0 destination retires with no write.
  - When retire is 0, rf_we_wb_o = 0. In that case rf_waddr_wb_o and rf_wdata_wb_o hold the head fields, or 0 when the buffer is empty.
- Forwarding, per port p ∈ {a, b}: take the youngest valid entry with we && addr != 0 && addr == raddr_p_i.
  - If that entry is filled: fwd_p_valid_o = 1 and fwd_p_data_o = its data.
  - If it is unfilled: hazard_o = 1 and fwd_p_valid_o = 0.
  - If no entry matches, or raddr_p_i == 0: fwd_p_valid_o = 0 and fwd_p_data_o = 0.
- A register file read returns the pre-retire value during the retire cycle. Forwarding covers that cycle because the retiring entry is still valid.
- The count update follows the rule count_next = count + push - retire.

## Timing
- On reset (rst_ni = 0 at a clock edge), all entries, pointers and count are cleared.
- While rst_ni = 0:
  - wb_ready_o, rf_we_wb_o, fwd_*_valid_o and hazard_o are forced to 0.
  - The data and address outputs are 0.
  - count_o = 0.
- A non-load pushed at edge N retires, with rf_we_wb_o high, in cycle N+1. Its value reaches rdata_*_o of the register file from cycle N+2.
- A load whose response arrives in cycle M retires in cycle M+1, provided it is at the head.
- All forwarding and hazard outputs are combinational from state and raddr_*_i.
- wb_ready_o depends combinationally on state only, not on en_wb_i.
- Reset mid-operation discards all pending entries, including unfilled loads. A late LSU response after reset is dropped.

## Configuration
- IBEX_WB_FWD_EN defined: forwarding operates as specified under Operation.
- IBEX_WB_FWD_EN undefined:
  - fwd_a_valid_o and fwd_b_valid_o are tied to 0, and fwd_*_data_o are tied to 0.
  - hazard_o = 1 whenever any valid entry with we && addr != 0 matches a nonzero raddr_a_i or raddr_b_i, whether or not that entry is filled.

## Test plan
- Push a non-load with addr 5, data 0xDEADBEEF at edge 0 → cycle 1: rf_we_wb_o=1, rf_waddr_wb_o=5, rf_wdata_wb_o=0xDEADBEEF, count_o=1. Cycle 2: count_o=0.
- Push a load to x3, then a non-load to x4 (0x11). Hold off the LSU for 3 cycles, then send response 0x22 → no write occurs until the response. Then x3=0x22 and x4=0x11 retire on consecutive cycles. With raddr_a_i=3 before the response: hazard_o=1.
- Depth=2: with the buffer full of unfilled loads → wb_ready_o=0. Send one response → in the next cycle the head retires and wb_ready_o=1. A push in that cycle is accepted (pop+push) and count_o stays 2.
- Two filled entries to x7 holding 0xA then 0xB, with raddr_b_i=7 → fwd_b_valid_o=1, fwd_b_data_o=0xB. With raddr_a_i=0 → fwd_a_valid_o=0.
- Load to x9 with lsu_resp_err_i=1, and a non-load to x0 → both retire with rf_we_wb_o=0. A spurious lsu_resp_valid_i while the buffer is empty → no effect.
- Assert rst_ni=0 with 2 entries pending → the next cycle has count_o=0 and no writes. A following LSU response is dropped.
